// File: rtl/cbfp_frame_ctrl_if.sv
// Upstream beat handshake into the CBFP frame controller.
// The master drives beats; the slave (controller) returns ready.
interface cbfp_frame_ctrl_if;
   logic s_valid;
   logic s_last;
   logic s_ready;

   modport master (output s_valid, output s_last, input s_ready);
   modport slave  (input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/cbfp_frame_ctrl.sv
// Frame sequencer in front of cbfp_module: accepts a frame of beats, appends zero flush beats,
// then counts returned valid_out beats to close the frame, with sticky length/spurious/timeout flags.
module cbfp_frame_ctrl #(
   parameter int unsigned LANES     = 16,
   parameter int unsigned FRAME_LEN = 512,
   parameter int unsigned FLUSH_CYC = 4,
   parameter int unsigned TIMEOUT   = 64,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   enable,
   input  logic                                   clr_err,
   cbfp_frame_ctrl_if.slave                       up,
   output logic                                   cbfp_valid_in,
   output logic                                   cbfp_zero,
   input  logic                                   cbfp_valid_out,
   output logic [$clog2(FRAME_LEN / LANES)-1:0]   beat_idx,
   output logic                                   busy,
   output logic                                   done_pulse,
   output logic [CNT_W-1:0]                       frame_cnt,
   output logic [CNT_W-1:0]                       blk_cnt,
   output logic                                   err_len,
   output logic                                   err_spur,
   output logic                                   err_tmo
);

   localparam int unsigned BEATS = FRAME_LEN / LANES;
   localparam int unsigned IDX_W = $clog2(BEATS);
   localparam int unsigned FL_W  = $clog2(FLUSH_CYC + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   typedef enum logic [1:0] {StIdle, StStream, StFlush, StDrain} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] beat_q, beat_d;
   logic [IDX_W-1:0] out_q, out_d;
   logic [FL_W-1:0]  flush_q, flush_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] frame_q, frame_d;
   logic [CNT_W-1:0] blk_q, blk_d;
   logic             done_q, done_d;
   logic             err_len_q, err_len_d;
   logic             err_spur_q, err_spur_d;
   logic             err_tmo_q, err_tmo_d;
   logic             acc, len_set, spur_set, tmo_set;

   // rst_n gates ready so the handshake drops the instant reset asserts.
   assign up.s_ready = (state_q == StIdle) ? (enable & rst_n) : (state_q == StStream);
   assign acc        = up.s_valid & up.s_ready;

   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      out_d         = out_q;
      flush_d       = flush_q;
      tmo_d         = tmo_q;
      frame_d       = frame_q;
      blk_d         = blk_q;
      done_d        = 1'b0;
      len_set       = 1'b0;
      spur_set      = 1'b0;
      tmo_set       = 1'b0;
      cbfp_valid_in = 1'b0;
      cbfp_zero     = 1'b0;

      unique case (state_q)
         StIdle, StStream: begin
            cbfp_valid_in = acc;
            if (acc) begin
               len_set = up.s_last ^ (beat_q == LAST_IDX);
               if (beat_q == LAST_IDX) begin
                  beat_d  = '0;
                  flush_d = FL_W'(FLUSH_CYC);
                  state_d = StFlush;
               end else begin
                  beat_d  = beat_q + IDX_W'(1);
                  state_d = StStream;
               end
            end
         end
         StFlush: begin
            cbfp_valid_in = 1'b1;
            cbfp_zero     = 1'b1;
            flush_d       = flush_q - FL_W'(1);
            if (flush_q == FL_W'(1)) begin
               tmo_d   = '0;
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (cbfp_valid_out) begin
               tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               tmo_set = 1'b1;
               tmo_d   = '0;
               out_d   = '0;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Returned beats are tracked in every state; a wrap in DRAIN closes the frame.
      if (cbfp_valid_out) begin
         blk_d    = blk_q + CNT_W'(1);
         spur_set = (state_q == StIdle);
         if (out_q == LAST_IDX) begin
            out_d   = '0;
            done_d  = 1'b1;
            frame_d = frame_q + CNT_W'(1);
            if (state_q == StDrain) state_d = StIdle;
         end else begin
            out_d = out_q + IDX_W'(1);
         end
      end

      err_len_d  = (err_len_q  & ~clr_err) | len_set;
      err_spur_d = (err_spur_q & ~clr_err) | spur_set;
      err_tmo_d  = (err_tmo_q  & ~clr_err) | tmo_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         beat_q     <= '0;
         out_q      <= '0;
         flush_q    <= '0;
         tmo_q      <= '0;
         frame_q    <= '0;
         blk_q      <= '0;
         done_q     <= 1'b0;
         err_len_q  <= 1'b0;
         err_spur_q <= 1'b0;
         err_tmo_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         out_q      <= out_d;
         flush_q    <= flush_d;
         tmo_q      <= tmo_d;
         frame_q    <= frame_d;
         blk_q      <= blk_d;
         done_q     <= done_d;
         err_len_q  <= err_len_d;
         err_spur_q <= err_spur_d;
         err_tmo_q  <= err_tmo_d;
      end
   end

   assign beat_idx   = beat_q;
   assign busy       = (state_q != StIdle);
   assign done_pulse = done_q;
   assign frame_cnt  = frame_q;
   assign blk_cnt    = blk_q;
   assign err_len    = err_len_q;
   assign err_spur   = err_spur_q;
   assign err_tmo    = err_tmo_q;

endmodule

// File: tb/tb_cbfp_frame_ctrl.sv
// Bench for cbfp_frame_ctrl: a count-based frame model checked every cycle, plus directed
// scenarios with literal expectations for counts, flags and reset behaviour.
module tb_cbfp_frame_ctrl;

   localparam int BEATS   = 32;
   localparam int FLUSH   = 4;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        clr_err = 1'b0;
   logic        valid_out = 1'b0;
   logic        cbfp_valid_in, cbfp_zero, busy, done_pulse;
   logic        err_len, err_spur, err_tmo;
   logic [4:0]  beat_idx;
   logic [15:0] frame_cnt, blk_cnt;

   int n_vec = 0;
   int n_err = 0;
   int acc_seen, zero_seen, done_seen;

   always #5 clk = ~clk;

   cbfp_frame_ctrl_if up_if ();

   cbfp_frame_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .clr_err        (clr_err),
      .up             (up_if),
      .cbfp_valid_in  (cbfp_valid_in),
      .cbfp_zero      (cbfp_zero),
      .cbfp_valid_out (valid_out),
      .beat_idx       (beat_idx),
      .busy           (busy),
      .done_pulse     (done_pulse),
      .frame_cnt      (frame_cnt),
      .blk_cnt        (blk_cnt),
      .err_len        (err_len),
      .err_spur       (err_spur),
      .err_tmo        (err_tmo)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
      end
   endtask

   // Model: a frame is "beats taken so far", then "flush beats issued", then quiet drain cycles.
   bit          m_active;
   int          m_beats, m_flush, m_quiet, m_outmod;
   logic [15:0] m_frames, m_blk;
   bit          m_done, m_elen, m_espur, m_etmo;
   bit          w_idle, w_drain, w_acc, s_len, s_spur, s_tmo;

   function automatic bit m_ready();
      return m_active ? (m_beats < BEATS) : enable;
   endfunction

   function automatic bit m_zero();
      return m_active && m_beats == BEATS && m_flush < FLUSH;
   endfunction

   function automatic bit m_vin();
      if (!m_active || m_beats < BEATS) return up_if.s_valid & m_ready();
      return m_zero();
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_active = 0; m_beats = 0; m_flush = 0; m_quiet = 0; m_outmod = 0;
         m_frames = '0; m_blk = '0; m_done = 0; m_elen = 0; m_espur = 0; m_etmo = 0;
      end else begin
         w_idle  = !m_active;
         w_drain = m_active && m_beats == BEATS && m_flush == FLUSH;
         w_acc   = up_if.s_valid && m_ready();
         s_len = 0; s_spur = 0; s_tmo = 0;
         if (w_idle) begin
            if (w_acc) begin
               m_active = 1; m_beats = 1; m_flush = 0;
               s_len = up_if.s_last;
            end
         end else if (m_beats < BEATS) begin
            if (w_acc) begin
               s_len = up_if.s_last != (m_beats == BEATS - 1);
               m_beats++;
            end
         end else if (m_flush < FLUSH) begin
            m_flush++;
            m_quiet = 0;
         end else if (valid_out) begin
            m_quiet = 0;
         end else begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
               s_tmo = 1; m_active = 0; m_outmod = 0;
            end
         end
         m_done = 0;
         if (valid_out) begin
            m_blk++;
            s_spur = w_idle;
            m_outmod++;
            if (m_outmod == BEATS) begin
               m_outmod = 0; m_done = 1; m_frames++;
               if (w_drain) m_active = 0;
            end
         end
         m_elen  = (m_elen  && !clr_err) || s_len;
         m_espur = (m_espur && !clr_err) || s_spur;
         m_etmo  = (m_etmo  && !clr_err) || s_tmo;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("s_ready",       up_if.s_ready, m_ready());
         chk("cbfp_valid_in", cbfp_valid_in, m_vin());
         chk("cbfp_zero",     cbfp_zero,     m_zero());
         chk("beat_idx",      beat_idx,      m_active ? m_beats % BEATS : 0);
         chk("busy",          busy,          m_active);
         chk("done_pulse",    done_pulse,    m_done);
         chk("frame_cnt",     frame_cnt,     m_frames);
         chk("blk_cnt",       blk_cnt,       m_blk);
         chk("err_len",       err_len,       m_elen);
         chk("err_spur",      err_spur,      m_espur);
         chk("err_tmo",       err_tmo,       m_etmo);
         acc_seen  += int'(up_if.s_valid & up_if.s_ready);
         zero_seen += int'(cbfp_zero);
         done_seen += int'(done_pulse);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      acc_seen = 0; zero_seen = 0; done_seen = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         step();
         n++;
      end
      if (busy) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_idle: busy=1 after 200 cycles, required 0");
      end
   endtask

   task automatic send_frame(input bit gap, input int last_at);
      for (int i = 0; i < BEATS; i++) begin
         up_if.s_valid = 1'b1;
         up_if.s_last  = (i == last_at);
         step();
         if (gap) begin
            up_if.s_valid = 1'b0;
            up_if.s_last  = 1'b0;
            step();
         end
      end
      up_if.s_valid = 1'b0;
      up_if.s_last  = 1'b0;
   endtask

   task automatic emit_outputs(input int n);
      for (int k = 0; k < n; k++) begin
         valid_out = 1'b1;
         step();
      end
      valid_out = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      up_if.s_valid = 1'b1;
      up_if.s_last  = 1'b0;
      enable        = 1'b1;
      #3;
      chk("reset s_ready",  up_if.s_ready, 0);
      chk("reset valid_in", cbfp_valid_in, 0);
      chk("reset busy",     busy,          0);
      chk("reset frames",   frame_cnt,     0);
      up_if.s_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();

      // Single clean frame.
      clear_counts();
      send_frame(0, 31);
      emit_outputs(32);
      repeat (3) step();
      chk("t1 acc",    acc_seen,  32);
      chk("t1 zero",   zero_seen, 4);
      chk("t1 done",   done_seen, 1);
      chk("t1 frames", frame_cnt, 1);
      chk("t1 blk",    blk_cnt,   32);
      chk("t1 errs",   {err_len, err_spur, err_tmo}, 0);

      // Upstream gaps every other cycle.
      wait_idle();
      clear_counts();
      send_frame(1, 31);
      emit_outputs(32);
      repeat (3) step();
      chk("t2 acc",    acc_seen,  32);
      chk("t2 zero",   zero_seen, 4);
      chk("t2 frames", frame_cnt, 2);

      // Early s_last on beat 20.
      wait_idle();
      clear_counts();
      send_frame(0, 20);
      chk("t3 err_len", err_len, 1);
      emit_outputs(32);
      repeat (3) step();
      chk("t3 acc",    acc_seen,  32);
      chk("t3 frames", frame_cnt, 3);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t3 cleared", err_len, 0);

      // Drain timeout with no returned beats.
      wait_idle();
      clear_counts();
      send_frame(0, 31);
      repeat (FLUSH + TIMEOUT + 3) step();
      chk("t4 err_tmo", err_tmo,   1);
      chk("t4 busy",    busy,      0);
      chk("t4 frames",  frame_cnt, 3);
      chk("t4 done",    done_seen, 0);
      chk("t4 blk",     blk_cnt,   96);

      // Spurious valid_out in IDLE with enable low, after a fresh reset.
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      enable        = 1'b0;
      up_if.s_valid = 1'b1;
      valid_out     = 1'b1;
      @(negedge clk);
      chk("t5 s_ready",  up_if.s_ready, 0);
      chk("t5 valid_in", cbfp_valid_in, 0);
      step();
      valid_out     = 1'b0;
      up_if.s_valid = 1'b0;
      @(negedge clk);
      chk("t5 err_spur", err_spur, 1);
      chk("t5 blk",      blk_cnt,  1);
      chk("t5 busy",     busy,     0);

      // Asynchronous reset during the second flush cycle, then a clean frame.
      step();
      enable = 1'b1;
      send_frame(0, 31);
      step();
      #2 rst_n = 1'b0;
      up_if.s_valid = 1'b1;
      #1;
      chk("t6 s_ready",  up_if.s_ready, 0);
      chk("t6 valid_in", cbfp_valid_in, 0);
      chk("t6 zero",     cbfp_zero,     0);
      chk("t6 busy",     busy,          0);
      chk("t6 blk",      blk_cnt,       0);
      chk("t6 err_spur", err_spur,      0);
      up_if.s_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      clear_counts();
      send_frame(0, 31);
      emit_outputs(32);
      repeat (3) step();
      chk("t6 frames", frame_cnt, 1);
      chk("t6 blk2",   blk_cnt,   32);
      chk("t6 done",   done_seen, 1);
      chk("t6 errs",   {err_len, err_spur, err_tmo}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cbfp_frame_ctrl.md
Name: cbfp_frame_ctrl

Overview:
- Frame-level sequencer placed in front of the 16-lane cbfp_module in the FFT stage pipeline.
- Accepts 512-sample frames from upstream as 32 beats of 16 lanes over a valid/ready handshake, and generates cbfp valid_in.
- Injects a fixed zero-data flush tail so the last CBFP block drains without upstream help.
- Counts returned valid_out beats to close each frame, and flags length, spurious-output and timeout errors.

Parameters:
- LANES, 16, samples per beat.
- FRAME_LEN, 512, samples per frame; BEATS = FRAME_LEN/LANES = 32.
- FLUSH_CYC, 4, number of zero-data valid cycles issued after the last input beat.
- TIMEOUT, 64, maximum cycles in DRAIN without a valid_out before aborting.
- CNT_W, 16, width of the frame and block counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  permits starting a new frame; sampled only in IDLE.
- clr_err  in  1  synchronous clear of all sticky error flags.
- s_valid  in  1  upstream beat valid.
- s_last  in  1  upstream marks the final beat of a frame.
- s_ready  out  1  controller accepts a beat; combinational from state and enable.
- cbfp_valid_in  out  1  drives cbfp_module valid_in.
- cbfp_zero  out  1  tells the datapath mux to force data and index inputs to 0 (flush beats).
- cbfp_valid_out  in  1  cbfp_module valid_out.
- beat_idx  out  5  index of the next input beat in the frame, 0..BEATS-1.
- busy  out  1  high in any state other than IDLE.
- done_pulse  out  1  one-cycle pulse when BEATS output beats of a frame have been received.
- frame_cnt  out  CNT_W  completed frames; wraps modulo 2^CNT_W.
- blk_cnt  out  CNT_W  total valid_out beats seen; wraps.
- err_len  out  1  sticky: s_last on the wrong beat, or missing on beat BEATS-1.
- err_spur  out  1  sticky: valid_out seen while in IDLE.
- err_tmo  out  1  sticky: DRAIN timeout.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0.
- Accepted beat: acc = s_valid & s_ready.
- States: IDLE, STREAM, FLUSH, DRAIN.
- IDLE:
  - s_ready = enable.
  - On acc: beat_idx becomes 1, go to STREAM.
- STREAM:
  - s_ready = 1.
  - Each acc increments beat_idx.
  - Upstream gaps (s_valid=0) produce cbfp_valid_in=0; no timeout applies while in STREAM.
  - On acc with beat_idx = BEATS-1: beat_idx becomes 0, flush_cnt loads FLUSH_CYC, go to FLUSH.
- cbfp_valid_in = acc in IDLE and STREAM; data passes through combinationally with zero added latency.
- s_last checking:
  - s_last must be 1 exactly on beat BEATS-1.
  - s_last=1 on an earlier beat sets err_len; the frame still continues to BEATS beats.
  - s_last=0 on beat BEATS-1 sets err_len.
- FLUSH:
  - s_ready = 0, cbfp_valid_in = 1, cbfp_zero = 1 for exactly FLUSH_CYC consecutive cycles.
  - Then go to DRAIN with tmo_cnt = 0.
- DRAIN:
  - s_ready = 0, cbfp_valid_in = 0.
  - tmo_cnt increments each cycle without valid_out and clears on valid_out.
  - tmo_cnt reaching TIMEOUT sets err_tmo, clears out_cnt, goes to IDLE; no done_pulse.
- Output tracking (all states):
  - Each cbfp_valid_out increments blk_cnt and out_cnt; out_cnt counts 0..BEATS-1.
  - When out_cnt wraps from BEATS-1 to 0, done_pulse=1 on the next cycle and frame_cnt increments.
  - If the wrap occurs in DRAIN, go to IDLE in the same cycle.
  - valid_out in IDLE sets err_spur and is still counted.
- Back-to-back frames:
  - A new frame is accepted only once the controller is back in IDLE.
  - Minimum gap between frames = FLUSH_CYC + DRAIN residency.
- Simultaneous events:
  - clr_err and an error condition in the same cycle: the error wins, flag stays 1.
  - valid_out on the last FLUSH cycle is counted normally.
- enable:
  - Dropping enable mid-frame has no effect; the current frame completes.
  - enable low in IDLE holds s_ready=0.
- Reset mid-operation: immediate return to IDLE with all counters and flags zeroed. cbfp_valid_in and s_ready go low asynchronously.

Test Plan:
- Single frame: 32 beats with s_valid continuous and s_last on beat 31; DUT valid_out returns 32 beats → exactly 32 acc cycles, then 4 cycles of cbfp_valid_in=cbfp_zero=1, done_pulse once, frame_cnt=1, blk_cnt=32, no errors.
- Upstream gaps: s_valid toggling 1/0 per cycle for one frame → cbfp_valid_in mirrors acc, beat_idx advances only on acc, FLUSH begins the cycle after the 32nd acc.
- Length error: s_last on beat 20 → err_len=1 from the cycle after beat 20, frame still runs 32 beats; clr_err pulse then clears err_len to 0.
- Timeout: after FLUSH, hold valid_out=0 → err_tmo=1 after 64 DRAIN cycles, state IDLE, frame_cnt unchanged, no done_pulse.
- Spurious output and enable: enable=0 with valid_out pulsed in IDLE → s_ready=0, err_spur=1, blk_cnt=1.
- Async reset during FLUSH cycle 2 → all outputs 0 immediately; a subsequent clean frame completes with frame_cnt=1.
